instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: AUTO_DELAY_SLOT, default 1, meaning: when 1, a NOP (32'h0000_0000) is emitted automatically after every branch or jump word.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: req_valid  input  1  encode request present.
REQ-005 Port: req_ready  output  1  encoder accepts the request this cycle.
REQ-006 Port: req_op  input  encode_op_t  operation to encode.
REQ-007 Port: req_rs, req_rt, req_rd  input  5 each  register fields.
REQ-008 Port: req_shamt  input  5  shift amount field for R-type.
REQ-009 Port: req_imm  input  26  immediate; low 16 bits for I-type, all 26 bits for J/JAL.
REQ-010 Port: instr_valid  output  1  instr holds a valid word.
REQ-011 Port: instr_ready  input  1  consumer takes the word.
REQ-012 Port: instr  output  32  encoded MIPS32 instruction.
REQ-013 Port: bad_op  output  1  sticky flag: an unsupported req_op was accepted.
REQ-014 Port: clear_err  input  1  synchronous clear of bad_op.
REQ-015 Port: word_count  output  16  count of output handshakes.

Function
REQ-016 Request handshake: a request is accepted on an edge where req_valid && req_ready; word transfer occurs when instr_valid && instr_ready.
REQ-017 req_ready = (state == NORMAL) && (!instr_valid || instr_ready); it has no combinational path from req_valid.
REQ-018 Latency: an accepted request appears on instr with instr_valid=1 on the next cycle; full throughput is one word per cycle under continuous instr_ready.
REQ-019 instr and instr_valid are registered, and both hold stable while instr_valid && !instr_ready.
REQ-020 Encoding formats:
- R-type (ADD, ADDU, SUB, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA): {6'h00, rs, rt, rd, shamt, funct}.
- I-type (ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, BEQ, BNE, loads, stores): {opcode, rs, rt, imm[15:0]}.
- J/JAL: {opcode, imm[25:0]}.
REQ-021 Forced fields:
- BLEZ/BGTZ: rt field forced to 0.
- LUI: rs field forced to 0.
- Non-shift R-type: shamt forced to 0.
- Shifts: rs forced to 0.
REQ-022 States:
- NORMAL: accept requests.
- SLOT: NOP pending; req_ready=0.
REQ-023 NORMAL->SLOT transition: on accepting BEQ/BNE/BLEZ/BGTZ/J/JAL when AUTO_DELAY_SLOT=1; otherwise the state remains NORMAL.
REQ-024 SLOT->NORMAL transition: when !instr_valid || instr_ready, load instr=32'h0 with instr_valid=1 and return to NORMAL.
REQ-025 Unsupported req_op: the request is accepted, no word is emitted, and bad_op is set.
REQ-026 If clear_err and a bad accept occur in the same cycle, bad_op is set (set wins).
REQ-027 word_count increments on every output handshake, including NOPs, and wraps 16'hFFFF->16'h0000.
REQ-028 When there is no new load and the word is transferred, instr_valid drops to 0 on the next cycle.

Reset
REQ-029 rst_n low immediately forces: state=NORMAL, instr_valid=0, instr=32'h0, bad_op=0, word_count=0.
REQ-030 Reset asserted mid-SLOT discards the pending NOP.
REQ-031 While rst_n is low, req_ready=0.
REQ-032 After deassertion, the first request is acceptable on the first edge with rst_n high.

Structure
REQ-033 Shared package: encode_op_t enum, funct constants, and a helper classifying an op as branch/jump; opcode values reuse the existing main_opcode package constants.
REQ-034 One combinational sub-module, encode_fields (op + fields -> 32-bit word + supported flag + is_branch flag); instr_encoder holds the FSM, output register and counters.

Verification
REQ-035 ADDIU rs=1 rt=2 imm=16'h0005 -> instr=32'h2422_0005 one cycle after accept; word_count=1 after the handshake.
REQ-036 ADDU rd=3 rs=1 rt=2 then LW rt=4 rs=29 imm=16'h0010 back-to-back with instr_ready=1 -> 32'h0022_1821 then 32'h8FA4_0010 on consecutive cycles.
REQ-037 BEQ rs=1 rt=2 imm=3, then J imm=26'h40 with AUTO_DELAY_SLOT=1 -> 32'h1022_0003, 32'h0000_0000, 32'h0800_0040, 32'h0000_0000; req_ready=0 during each SLOT cycle.
REQ-038 Hold instr_ready=0 for 3 cycles after a word -> instr stable, req_ready=0 throughout, and no word is lost afterwards.
REQ-039 Unsupported op accepted -> no instr_valid, bad_op=1; clear_err pulse -> bad_op=0; 65536 handshakes -> word_count=0.
REQ-040 rst_n pulsed low while in SLOT -> instr_valid=0 immediately; no NOP is emitted after release.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the MIPS32 instruction encoder.
// Main opcodes mirror the main_opcode encoding; funct codes cover the SPECIAL group.
package instr_encoder_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 26;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned FUNCT_W = 6;

  typedef enum logic [OP_W-1:0] {
    OP_ADD,  OP_ADDU, OP_SUB,   OP_SUBU, OP_AND,  OP_OR,   OP_XOR,  OP_SLT,
    OP_SLTU, OP_SLL,  OP_SRL,   OP_SRA,  OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
    OP_ANDI, OP_ORI,  OP_XORI,  OP_LUI,  OP_BEQ,  OP_BNE,  OP_BLEZ, OP_BGTZ,
    OP_LB,   OP_LH,   OP_LW,    OP_LBU,  OP_LHU,  OP_SB,   OP_SH,   OP_SW,
    OP_J,    OP_JAL
  } encode_op_t;

  // Main opcode field values
  localparam logic [OPC_W-1:0] OPC_SPECIAL = 6'h00;
  localparam logic [OPC_W-1:0] OPC_J       = 6'h02;
  localparam logic [OPC_W-1:0] OPC_JAL     = 6'h03;
  localparam logic [OPC_W-1:0] OPC_BEQ     = 6'h04;
  localparam logic [OPC_W-1:0] OPC_BNE     = 6'h05;
  localparam logic [OPC_W-1:0] OPC_BLEZ    = 6'h06;
  localparam logic [OPC_W-1:0] OPC_BGTZ    = 6'h07;
  localparam logic [OPC_W-1:0] OPC_ADDI    = 6'h08;
  localparam logic [OPC_W-1:0] OPC_ADDIU   = 6'h09;
  localparam logic [OPC_W-1:0] OPC_SLTI    = 6'h0A;
  localparam logic [OPC_W-1:0] OPC_SLTIU   = 6'h0B;
  localparam logic [OPC_W-1:0] OPC_ANDI    = 6'h0C;
  localparam logic [OPC_W-1:0] OPC_ORI     = 6'h0D;
  localparam logic [OPC_W-1:0] OPC_XORI    = 6'h0E;
  localparam logic [OPC_W-1:0] OPC_LUI     = 6'h0F;
  localparam logic [OPC_W-1:0] OPC_LB      = 6'h20;
  localparam logic [OPC_W-1:0] OPC_LH      = 6'h21;
  localparam logic [OPC_W-1:0] OPC_LW      = 6'h23;
  localparam logic [OPC_W-1:0] OPC_LBU     = 6'h24;
  localparam logic [OPC_W-1:0] OPC_LHU     = 6'h25;
  localparam logic [OPC_W-1:0] OPC_SB      = 6'h28;
  localparam logic [OPC_W-1:0] OPC_SH      = 6'h29;
  localparam logic [OPC_W-1:0] OPC_SW      = 6'h2B;

  // SPECIAL-group funct values
  localparam logic [FUNCT_W-1:0] FN_SLL  = 6'h00;
  localparam logic [FUNCT_W-1:0] FN_SRL  = 6'h02;
  localparam logic [FUNCT_W-1:0] FN_SRA  = 6'h03;
  localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
  localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;
  localparam logic [FUNCT_W-1:0] FN_AND  = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR   = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_XOR  = 6'h26;
  localparam logic [FUNCT_W-1:0] FN_SLT  = 6'h2A;
  localparam logic [FUNCT_W-1:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} enc_fmt_t;

  typedef enum logic {ST_NORMAL, ST_SLOT} enc_state_t;

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] shamt;
    logic [IMM_W-1:0] imm;
  } enc_fields_t;

  // Ops that transfer control and therefore take a delay slot
  function automatic logic is_branch_jump(input encode_op_t op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) ||
           (op == OP_BGTZ) || (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/encode_fields.sv
// Combinational field packer: operation plus operand fields to a MIPS32 word,
// with forced-zero fields applied and flags for supported / branch-class ops.
module encode_fields
  import instr_encoder_pkg::*;
(
  input  encode_op_t         i_op,
  input  enc_fields_t        i_fields,
  output logic [INSTR_W-1:0] o_word_c,
  output logic               o_supported_c,
  output logic               o_is_branch_c
);

  enc_fmt_t             w_fmt;
  logic [OPC_W-1:0]     w_opcode;
  logic [FUNCT_W-1:0]   w_funct;
  logic [REG_W-1:0]     w_rs;
  logic [REG_W-1:0]     w_rt;
  logic [REG_W-1:0]     w_shamt;
  logic                 w_shift;

  // Decode op into format, opcode/funct and field overrides
  always_comb begin
    w_fmt         = FMT_R;
    w_opcode      = OPC_SPECIAL;
    w_funct       = '0;
    w_shift       = 1'b0;
    w_rs          = i_fields.rs;
    w_rt          = i_fields.rt;
    o_supported_c = 1'b1;
    case (i_op)
      OP_ADD:   w_funct = FN_ADD;
      OP_ADDU:  w_funct = FN_ADDU;
      OP_SUB:   w_funct = FN_SUB;
      OP_SUBU:  w_funct = FN_SUBU;
      OP_AND:   w_funct = FN_AND;
      OP_OR:    w_funct = FN_OR;
      OP_XOR:   w_funct = FN_XOR;
      OP_SLT:   w_funct = FN_SLT;
      OP_SLTU:  w_funct = FN_SLTU;
      OP_SLL:   begin w_funct = FN_SLL; w_shift = 1'b1; end
      OP_SRL:   begin w_funct = FN_SRL; w_shift = 1'b1; end
      OP_SRA:   begin w_funct = FN_SRA; w_shift = 1'b1; end
      OP_ADDI:  begin w_fmt = FMT_I; w_opcode = OPC_ADDI;  end
      OP_ADDIU: begin w_fmt = FMT_I; w_opcode = OPC_ADDIU; end
      OP_SLTI:  begin w_fmt = FMT_I; w_opcode = OPC_SLTI;  end
      OP_SLTIU: begin w_fmt = FMT_I; w_opcode = OPC_SLTIU; end
      OP_ANDI:  begin w_fmt = FMT_I; w_opcode = OPC_ANDI;  end
      OP_ORI:   begin w_fmt = FMT_I; w_opcode = OPC_ORI;   end
      OP_XORI:  begin w_fmt = FMT_I; w_opcode = OPC_XORI;  end
      OP_LUI:   begin w_fmt = FMT_I; w_opcode = OPC_LUI;  w_rs = '0; end
      OP_BEQ:   begin w_fmt = FMT_I; w_opcode = OPC_BEQ;   end
      OP_BNE:   begin w_fmt = FMT_I; w_opcode = OPC_BNE;   end
      OP_BLEZ:  begin w_fmt = FMT_I; w_opcode = OPC_BLEZ; w_rt = '0; end
      OP_BGTZ:  begin w_fmt = FMT_I; w_opcode = OPC_BGTZ; w_rt = '0; end
      OP_LB:    begin w_fmt = FMT_I; w_opcode = OPC_LB;    end
      OP_LH:    begin w_fmt = FMT_I; w_opcode = OPC_LH;    end
      OP_LW:    begin w_fmt = FMT_I; w_opcode = OPC_LW;    end
      OP_LBU:   begin w_fmt = FMT_I; w_opcode = OPC_LBU;   end
      OP_LHU:   begin w_fmt = FMT_I; w_opcode = OPC_LHU;   end
      OP_SB:    begin w_fmt = FMT_I; w_opcode = OPC_SB;    end
      OP_SH:    begin w_fmt = FMT_I; w_opcode = OPC_SH;    end
      OP_SW:    begin w_fmt = FMT_I; w_opcode = OPC_SW;    end
      OP_J:     begin w_fmt = FMT_J; w_opcode = OPC_J;     end
      OP_JAL:   begin w_fmt = FMT_J; w_opcode = OPC_JAL;   end
      default:  o_supported_c = 1'b0;
    endcase
    // Shifts take their operand from rt and ignore rs; other R-types ignore shamt
    w_shamt = w_shift ? i_fields.shamt : '0;
    if (w_shift) w_rs = '0;
  end

  // Assemble the word in the selected format
  always_comb begin
    o_word_c = '0;
    case (w_fmt)
      FMT_R:   o_word_c = {OPC_SPECIAL, w_rs, w_rt, i_fields.rd, w_shamt, w_funct};
      FMT_I:   o_word_c = {w_opcode, w_rs, w_rt, i_fields.imm[15:0]};
      FMT_J:   o_word_c = {w_opcode, i_fields.imm};
      default: o_word_c = '0;
    endcase
  end

  assign o_is_branch_c = o_supported_c && is_branch_jump(i_op);

endmodule

// File: rtl/instr_encoder.sv
// Request/response wrapper around encode_fields: registered output word,
// optional automatic delay-slot NOP, sticky bad-op flag and handshake counter.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter bit AUTO_DELAY_SLOT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  encode_op_t         req_op,
  input  logic [REG_W-1:0]   req_rs,
  input  logic [REG_W-1:0]   req_rt,
  input  logic [REG_W-1:0]   req_rd,
  input  logic [REG_W-1:0]   req_shamt,
  input  logic [IMM_W-1:0]   req_imm,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic               bad_op,
  input  logic               clear_err,
  output logic [CNT_W-1:0]   word_count
);

  enc_state_t          r_state;
  enc_state_t          w_state_nxt;
  logic [INSTR_W-1:0]  r_instr;
  logic [INSTR_W-1:0]  w_instr_nxt;
  logic                r_instr_valid;
  logic                w_instr_valid_nxt;
  logic                r_bad_op;
  logic                w_bad_op_nxt;
  logic [CNT_W-1:0]    r_word_count;
  logic [CNT_W-1:0]    w_word_count_nxt;

  enc_fields_t         w_fields;
  logic [INSTR_W-1:0]  w_word;
  logic                w_supported;
  logic                w_is_branch;
  logic                w_out_free;
  logic                w_out_hs;
  logic                w_accept;

  assign w_fields = '{rs: req_rs, rt: req_rt, rd: req_rd, shamt: req_shamt, imm: req_imm};

  encode_fields u_encode_fields (
    .i_op          (req_op),
    .i_fields      (w_fields),
    .o_word_c      (w_word),
    .o_supported_c (w_supported),
    .o_is_branch_c (w_is_branch)
  );

  // Output register can take a new word when empty or being drained this cycle
  assign w_out_free = !r_instr_valid || instr_ready;
  assign w_out_hs   = r_instr_valid && instr_ready;
  assign req_ready  = rst_n && (r_state == ST_NORMAL) && w_out_free;
  assign w_accept   = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_NORMAL;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_bad_op      <= 1'b0;
      r_word_count  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_bad_op      <= w_bad_op_nxt;
      r_word_count  <= w_word_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_instr_nxt       = r_instr;
    w_instr_valid_nxt = r_instr_valid && !instr_ready;
    w_bad_op_nxt      = r_bad_op && !clear_err;
    w_word_count_nxt  = r_word_count + CNT_W'(w_out_hs);
    case (r_state)
      ST_NORMAL: begin
        if (w_accept) begin
          if (w_supported) begin
            w_instr_nxt       = w_word;
            w_instr_valid_nxt = 1'b1;
            if (AUTO_DELAY_SLOT && w_is_branch) w_state_nxt = ST_SLOT;
          end else begin
            // A bad accept overrides a same-cycle clear
            w_bad_op_nxt = 1'b1;
          end
        end
      end
      ST_SLOT: begin
        if (w_out_free) begin
          w_instr_nxt       = '0;
          w_instr_valid_nxt = 1'b1;
          w_state_nxt       = ST_NORMAL;
        end
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign bad_op      = r_bad_op;
  assign word_count  = r_word_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized plus directed bench for instr_encoder against a cycle-level
// behavioural model (output slot, pending NOP, sticky flag, counter).
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  encode_op_t  req_op = OP_ADD;
  logic [4:0]  req_rs = '0, req_rt = '0, req_rd = '0, req_shamt = '0;
  logic [25:0] req_imm = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic        bad_op;
  logic        clear_err = 1'b0;
  logic [15:0] word_count;

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_valid, m_pend, m_bad;
  logic [31:0] m_word;
  logic [15:0] m_cnt;

  instr_encoder #(.AUTO_DELAY_SLOT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_imm(req_imm), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .bad_op(bad_op),
    .clear_err(clear_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference encoder built from the MIPS32 field layout with plain arithmetic
  function automatic void ref_enc(input encode_op_t op, input logic [4:0] rs, rt, rd, sh,
                                  input logic [25:0] imm, output logic [31:0] w,
                                  output bit ok, output bit br);
    longint kind, code, vs, vt, vsh;
    kind = 1; code = 0; ok = 1'b1;
    vs = longint'(rs); vt = longint'(rt); vsh = longint'(sh);
    case (op)
      OP_ADD:  begin kind = 0; code = 32; end
      OP_ADDU: begin kind = 0; code = 33; end
      OP_SUB:  begin kind = 0; code = 34; end
      OP_SUBU: begin kind = 0; code = 35; end
      OP_AND:  begin kind = 0; code = 36; end
      OP_OR:   begin kind = 0; code = 37; end
      OP_XOR:  begin kind = 0; code = 38; end
      OP_SLT:  begin kind = 0; code = 42; end
      OP_SLTU: begin kind = 0; code = 43; end
      OP_SLL:  begin kind = 0; code = 0;  end
      OP_SRL:  begin kind = 0; code = 2;  end
      OP_SRA:  begin kind = 0; code = 3;  end
      OP_ADDI: code = 8;   OP_ADDIU: code = 9;  OP_SLTI: code = 10; OP_SLTIU: code = 11;
      OP_ANDI: code = 12;  OP_ORI:   code = 13; OP_XORI: code = 14; OP_LUI:   code = 15;
      OP_BEQ:  code = 4;   OP_BNE:   code = 5;  OP_BLEZ: code = 6;  OP_BGTZ:  code = 7;
      OP_LB:   code = 32;  OP_LH:    code = 33; OP_LW:   code = 35; OP_LBU:   code = 36;
      OP_LHU:  code = 37;  OP_SB:    code = 40; OP_SH:   code = 41; OP_SW:    code = 43;
      OP_J:    begin kind = 2; code = 2; end
      OP_JAL:  begin kind = 2; code = 3; end
      default: ok = 1'b0;
    endcase
    if (kind == 0) begin
      if (code < 4) vs = 0; else vsh = 0;
    end
    if (op == OP_LUI) vs = 0;
    if (op == OP_BLEZ || op == OP_BGTZ) vt = 0;
    br = ok && (op == OP_BEQ || op == OP_BNE || op == OP_BLEZ || op == OP_BGTZ ||
                op == OP_J || op == OP_JAL);
    if (kind == 0)
      w = 32'(vs * 2097152 + vt * 65536 + longint'(rd) * 2048 + vsh * 64 + code);
    else if (kind == 1)
      w = 32'(code * 67108864 + vs * 2097152 + vt * 65536 + longint'(imm) % 65536);
    else
      w = 32'(code * 67108864 + longint'(imm));
    if (!ok) w = '0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_pend = 1'b0; m_bad = 1'b0; m_word = '0; m_cnt = '0;
  endtask

  // One clock: drive, check observed outputs against the model, advance the model
  task automatic step(input bit v, input encode_op_t op, input logic [4:0] rs, rt, rd, sh,
                      input logic [25:0] imm, input bit rdy, input bit clr);
    logic [31:0] w;
    bit ok, br, free, exp_rr, acc;
    req_valid = v; req_op = op; req_rs = rs; req_rt = rt; req_rd = rd;
    req_shamt = sh; req_imm = imm; instr_ready = rdy; clear_err = clr;
    #3;
    free   = !m_valid || rdy;
    exp_rr = !m_pend && free;
    check("req_ready",   32'(req_ready),   32'(exp_rr));
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    if (m_valid) check("instr", instr, m_word);
    check("bad_op",      32'(bad_op),      32'(m_bad));
    check("word_count",  32'(word_count),  32'(m_cnt));
    acc = v && exp_rr;
    ref_enc(op, rs, rt, rd, sh, imm, w, ok, br);
    if (m_valid && rdy) begin m_cnt++; m_valid = 1'b0; end
    if (m_pend && free) begin
      m_valid = 1'b1; m_word = '0; m_pend = 1'b0;
    end else if (acc && ok) begin
      m_valid = 1'b1; m_word = w; m_pend = br;
    end
    if (acc && !ok) m_bad = 1'b1;
    else if (clr)   m_bad = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, OP_ADD, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, rdy, 1'b0);
  endtask

  initial begin
    encode_op_t bad_code;
    bad_code = encode_op_t'(6'd50);
    model_reset();
    #2;
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_req_ready",   32'(req_ready),   32'd0);
    check("rst_instr",       instr,            32'd0);
    check("rst_bad_op",      32'(bad_op),      32'd0);
    check("rst_word_count",  32'(word_count),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single ADDIU, accepted on the first edge after release
    step(1'b1, OP_ADDIU, 5'd1, 5'd2, 5'd0, 5'd0, 26'h5, 1'b1, 1'b0);
    check("addiu_word", instr, 32'h2422_0005);
    idle(1'b1);
    check("addiu_count", 32'(word_count), 32'd1);

    // Back-to-back ADDU then LW
    step(1'b1, OP_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0, 1'b1, 1'b0);
    check("addu_word", instr, 32'h0022_1821);
    step(1'b1, OP_LW, 5'd29, 5'd4, 5'd0, 5'd0, 26'h10, 1'b1, 1'b0);
    check("lw_word", instr, 32'h8FA4_0010);
    idle(1'b1);

    // BEQ then J with automatic delay slots
    step(1'b1, OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 26'h3, 1'b1, 1'b0);
    check("beq_word", instr, 32'h1022_0003);
    step(1'b1, OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 26'h40, 1'b1, 1'b0);
    check("beq_slot", instr, 32'h0);
    step(1'b1, OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 26'h40, 1'b1, 1'b0);
    check("j_word", instr, 32'h0800_0040);
    idle(1'b1);
    check("j_slot", instr, 32'h0);
    idle(1'b1);

    // Back-pressure for 3 cycles with requests waiting
    step(1'b1, OP_ORI, 5'd7, 5'd8, 5'd0, 5'd0, 26'hBEEF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, OP_XORI, 5'd3, 5'd9, 5'd0, 5'd0, 26'h1234, 1'b0, 1'b0);
    check("hold_word", instr, 32'h34E8_BEEF);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Unsupported op, clear, and clear/set collision
    step(1'b1, bad_code, 5'd1, 5'd1, 5'd1, 5'd1, 26'h1, 1'b1, 1'b0);
    check("bad_set", 32'(bad_op), 32'd1);
    step(1'b0, OP_ADD, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 1'b1);
    check("bad_clear", 32'(bad_op), 32'd0);
    step(1'b1, bad_code, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 1'b1);
    check("bad_set_wins", 32'(bad_op), 32'd1);
    step(1'b0, OP_ADD, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), encode_op_t'(6'($urandom_range(0, 39))),
           5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 26'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    // Reset while a delay-slot NOP is pending
    idle(1'b1); idle(1'b1);
    step(1'b1, OP_BNE, 5'd4, 5'd5, 5'd0, 5'd0, 26'h8, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("slot_rst_valid", 32'(instr_valid), 32'd0);
    check("slot_rst_ready", 32'(req_ready),   32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Counter wrap after 65536 handshakes from reset
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 65536; i++)
      step(1'b1, OP_ADD, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0, 26'd0, 1'b1, 1'b0);
    idle(1'b1);
    check("count_wrap", 32'(word_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
